// File: rtl/regbank_sequencer.sv
// Command-driven initiator for the 32x32 2R1W register bank: FILL, COPY, ADD and SWAP.
// It accepts one command at a time over valid/ready and drives the bank read/write ports.
module regbank_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_a,
  input  logic [AW-1:0] cmd_b,
  input  logic [AW-1:0] cmd_d,
  input  logic [AW:0]   cmd_len,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] sr1,
  output logic [AW-1:0] sr2,
  output logic [AW-1:0] wr,
  output logic          write,
  output logic [DW-1:0] writereg,
  input  logic [DW-1:0] readreg1,
  input  logic [DW-1:0] readreg2,
  output logic          busy,
  output logic          done
);

  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SWAP2, S_DONE} state_t;
  typedef enum logic [1:0] {OP_FILL = 2'b00, OP_COPY = 2'b01, OP_ADD = 2'b10, OP_SWAP = 2'b11} op_t;

  state_t        state_q;
  op_t           op_q;
  logic [AW-1:0] a_q, b_q, d_q;
  logic [LW-1:0] len_q, cnt_q;
  logic [DW-1:0] imm_q, tmp_q;
  logic [AW-1:0] sr1_q, sr2_q, wr_q;
  logic          write_q;

  logic [AW-1:0] step_d;
  logic          more_d;

  // step_d is the offset of the next element; indices wrap modulo the bank depth.
  always_comb begin
    step_d = cnt_q[AW-1:0] + AW'(1);
    more_d = (cnt_q + LW'(1)) < len_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_FILL;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      imm_q   <= '0;
      tmp_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      wr_q    <= '0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_t'(cmd_op);
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            d_q     <= cmd_d;
            len_q   <= cmd_len;
            imm_q   <= cmd_imm;
            cnt_q   <= '0;
            sr1_q   <= cmd_a;
            sr2_q   <= cmd_b;
            state_q <= S_EXEC;
            case (op_t'(cmd_op))
              OP_FILL, OP_COPY: begin
                wr_q    <= cmd_d;
                write_q <= (cmd_len != '0);
              end
              OP_ADD: begin
                wr_q    <= cmd_d;
                write_q <= 1'b1;
              end
              default: begin
                wr_q    <= cmd_a;
                write_q <= 1'b1;
              end
            endcase
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_FILL, OP_COPY: begin
              if (more_d) begin
                cnt_q   <= cnt_q + LW'(1);
                sr1_q   <= a_q + step_d;
                wr_q    <= d_q + step_d;
                write_q <= 1'b1;
              end else begin
                write_q <= 1'b0;
                state_q <= S_DONE;
              end
            end
            OP_ADD: begin
              write_q <= 1'b0;
              state_q <= S_DONE;
            end
            default: begin
              tmp_q   <= readreg1;
              wr_q    <= b_q;
              write_q <= 1'b1;
              state_q <= S_SWAP2;
            end
          endcase
        end
        S_SWAP2: begin
          write_q <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    writereg = '0;
    if (write_q) begin
      case (op_q)
        OP_FILL: writereg = imm_q;
        OP_COPY: writereg = readreg1;
        OP_ADD:  writereg = readreg1 + readreg2;
        OP_SWAP: writereg = (state_q == S_SWAP2) ? tmp_q : readreg2;
        default: writereg = '0;
      endcase
    end
  end

  assign sr1       = sr1_q;
  assign sr2       = sr2_q;
  assign wr        = wr_q;
  assign write     = write_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed bench for regbank_sequencer with a behavioural 32x32 bank attached.
module tb_regbank_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] sr1, sr2, wr;
  logic          write;
  logic [DW-1:0] writereg, readreg1, readreg2;
  logic          busy, done;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] bank [32];

  int nvec = 0;
  int nmis = 0;
  int            wl_wr[$];
  logic [DW-1:0] wl_data[$];
  int            wl_cyc[$];

  always #5 clk = ~clk;

  regbank_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_len(cmd_len), .cmd_imm(cmd_imm),
    .sr1(sr1), .sr2(sr2), .wr(wr), .write(write), .writereg(writereg),
    .readreg1(readreg1), .readreg2(readreg2), .busy(busy), .done(done)
  );

  assign readreg1 = bank[sr1];
  assign readreg2 = bank[sr2];
  always @(posedge clk) begin
    if (pl_en) bank[pl_idx] <= pl_data;
    else if (write) bank[wr] <= writereg;
  end

  task automatic preload(input int idx, input logic [DW-1:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = AW'(idx); pl_data = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic start_cmd(input logic [1:0] op, input int a, input int b, input int d,
                           input int len, input logic [DW-1:0] imm);
    @(negedge clk);
    cmd_op = op; cmd_a = AW'(a); cmd_b = AW'(b); cmd_d = AW'(d);
    cmd_len = LW'(len); cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic watch(input int max_c, output int done_c);
    wl_wr.delete(); wl_data.delete(); wl_cyc.delete();
    done_c = 0;
    for (int c = 1; c <= max_c && done_c == 0; c++) begin
      @(negedge clk);
      if (write === 1'b1) begin
        wl_wr.push_back(int'(wr)); wl_data.push_back(writereg); wl_cyc.push_back(c);
      end
      if (done === 1'b1) done_c = c;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    nvec++; if (write !== 1'b0) begin nmis++; $display("FAIL rst_write: got %b want 0", write); end
    nvec++; if (sr1 !== '0) begin nmis++; $display("FAIL rst_sr1: got %0d want 0", sr1); end
    nvec++; if (sr2 !== '0) begin nmis++; $display("FAIL rst_sr2: got %0d want 0", sr2); end
    nvec++; if (wr !== '0) begin nmis++; $display("FAIL rst_wr: got %0d want 0", wr); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL rst_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL rst_done: got %b want 0", done); end
    nvec++; if (writereg !== '0) begin nmis++; $display("FAIL rst_writereg: got %h want 0", writereg); end
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill_all();
    int dc;
    start_cmd(2'b00, 0, 0, 0, 32, 32'hA5A5_A5A5);
    watch(40, dc);
    nvec++; if (dc !== 33) begin nmis++; $display("FAIL fill_done_cycle: got %0d want 33", dc); end
    nvec++; if (wl_wr.size() !== 32) begin nmis++; $display("FAIL fill_nwrites: got %0d want 32", wl_wr.size()); end
    for (int i = 0; i < 32 && i < wl_wr.size(); i++) begin
      nvec++; if (wl_wr[i] !== i) begin nmis++; $display("FAIL fill_wr[%0d]: got %0d want %0d", i, wl_wr[i], i); end
      nvec++; if (wl_cyc[i] !== i + 1) begin nmis++; $display("FAIL fill_cycle[%0d]: got %0d want %0d", i, wl_cyc[i], i + 1); end
      nvec++; if (wl_data[i] !== 32'hA5A5_A5A5) begin nmis++; $display("FAIL fill_data[%0d]: got %h want a5a5a5a5", i, wl_data[i]); end
    end
    @(negedge clk);
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL fill_ready_after_done: got %b want 1", cmd_ready); end
    for (int i = 0; i < 32; i++) begin
      nvec++; if (bank[i] !== 32'hA5A5_A5A5) begin nmis++; $display("FAIL fill_bank[%0d]: got %h want a5a5a5a5", i, bank[i]); end
    end
  endtask

  task automatic test_copy();
    int dc;
    logic [DW-1:0] want;
    for (int i = 0; i < 32; i++) preload(i, DW'(i * 10));
    start_cmd(2'b01, 0, 0, 16, 8, '0);
    watch(20, dc);
    nvec++; if (dc !== 9) begin nmis++; $display("FAIL copy_done_cycle: got %0d want 9", dc); end
    nvec++; if (wl_wr.size() !== 8) begin nmis++; $display("FAIL copy_nwrites: got %0d want 8", wl_wr.size()); end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      want = (i >= 16 && i < 24) ? DW'((i - 16) * 10) : DW'(i * 10);
      nvec++; if (bank[i] !== want) begin nmis++; $display("FAIL copy_bank[%0d]: got %0d want %0d", i, bank[i], want); end
    end
  endtask

  task automatic test_fill_wrap();
    int dc;
    int exp_wr[4] = '{30, 31, 0, 1};
    start_cmd(2'b00, 0, 0, 30, 4, 32'd7);
    watch(10, dc);
    nvec++; if (dc !== 5) begin nmis++; $display("FAIL wrap_done_cycle: got %0d want 5", dc); end
    nvec++; if (wl_wr.size() !== 4) begin nmis++; $display("FAIL wrap_nwrites: got %0d want 4", wl_wr.size()); end
    for (int i = 0; i < 4 && i < wl_wr.size(); i++) begin
      nvec++; if (wl_wr[i] !== exp_wr[i]) begin nmis++; $display("FAIL wrap_wr[%0d]: got %0d want %0d", i, wl_wr[i], exp_wr[i]); end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (bank[exp_wr[i]] !== 32'd7) begin nmis++; $display("FAIL wrap_bank[%0d]: got %0d want 7", exp_wr[i], bank[exp_wr[i]]); end
    end
    nvec++; if (bank[2] !== 32'd20) begin nmis++; $display("FAIL wrap_bank2_kept: got %0d want 20", bank[2]); end
  endtask

  task automatic test_add();
    int dc;
    preload(3, 32'hFFFF_FFFF);
    preload(4, 32'd2);
    start_cmd(2'b10, 3, 4, 5, 7, '0);
    watch(10, dc);
    nvec++; if (dc !== 2) begin nmis++; $display("FAIL add_done_cycle: got %0d want 2", dc); end
    nvec++; if (wl_wr.size() !== 1) begin nmis++; $display("FAIL add_nwrites: got %0d want 1", wl_wr.size()); end
    if (wl_wr.size() > 0) begin
      nvec++; if (wl_wr[0] !== 5) begin nmis++; $display("FAIL add_wr: got %0d want 5", wl_wr[0]); end
      nvec++; if (wl_data[0] !== 32'h0000_0001) begin nmis++; $display("FAIL add_data: got %h want 00000001", wl_data[0]); end
    end
    @(negedge clk);
    nvec++; if (bank[5] !== 32'h0000_0001) begin nmis++; $display("FAIL add_bank5: got %h want 00000001", bank[5]); end
    nvec++; if (bank[3] !== 32'hFFFF_FFFF) begin nmis++; $display("FAIL add_bank3_kept: got %h want ffffffff", bank[3]); end
  endtask

  task automatic test_swap();
    int dc;
    preload(1, 32'd11);
    preload(2, 32'd22);
    start_cmd(2'b11, 1, 2, 9, 0, '0);
    watch(10, dc);
    nvec++; if (dc !== 3) begin nmis++; $display("FAIL swap_done_cycle: got %0d want 3", dc); end
    nvec++; if (wl_wr.size() !== 2) begin nmis++; $display("FAIL swap_nwrites: got %0d want 2", wl_wr.size()); end
    if (wl_wr.size() == 2) begin
      nvec++; if (wl_wr[0] !== 1 || wl_data[0] !== 32'd22) begin nmis++; $display("FAIL swap_first: got wr=%0d data=%0d want wr=1 data=22", wl_wr[0], wl_data[0]); end
      nvec++; if (wl_wr[1] !== 2 || wl_data[1] !== 32'd11) begin nmis++; $display("FAIL swap_second: got wr=%0d data=%0d want wr=2 data=11", wl_wr[1], wl_data[1]); end
    end
    @(negedge clk);
    nvec++; if (bank[1] !== 32'd22) begin nmis++; $display("FAIL swap_bank1: got %0d want 22", bank[1]); end
    nvec++; if (bank[2] !== 32'd11) begin nmis++; $display("FAIL swap_bank2: got %0d want 11", bank[2]); end
    nvec++; if (bank[9] !== 32'd90) begin nmis++; $display("FAIL swap_bank9_kept: got %0d want 90", bank[9]); end
    start_cmd(2'b11, 6, 6, 0, 0, '0);
    watch(10, dc);
    nvec++; if (dc !== 3) begin nmis++; $display("FAIL swap_same_done_cycle: got %0d want 3", dc); end
    nvec++; if (wl_wr.size() !== 2) begin nmis++; $display("FAIL swap_same_nwrites: got %0d want 2", wl_wr.size()); end
    @(negedge clk);
    nvec++; if (bank[6] !== 32'd60) begin nmis++; $display("FAIL swap_same_bank6: got %0d want 60", bank[6]); end
  endtask

  task automatic test_len0_hold();
    int wcnt = 0;
    @(negedge clk);
    cmd_op = 2'b01; cmd_a = AW'(0); cmd_d = AW'(8); cmd_len = '0; cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (write === 1'b1) wcnt++;
      case (c)
        1: begin
          nvec++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin nmis++; $display("FAIL hold_c1_busy: got busy=%b ready=%b want 1/0", busy, cmd_ready); end
          cmd_op = 2'b00; cmd_len = LW'(5);
        end
        2: begin
          nvec++; if (done !== 1'b1) begin nmis++; $display("FAIL hold_c2_done: got %b want 1", done); end
          cmd_op = 2'b01; cmd_len = '0;
        end
        3: begin
          nvec++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin nmis++; $display("FAIL hold_c3_ready: got ready=%b done=%b want 1/0", cmd_ready, done); end
        end
        4: begin
          nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL hold_second_accept: got busy=%b want 1", busy); end
          cmd_valid = 1'b0;
        end
        5: begin
          nvec++; if (done !== 1'b1) begin nmis++; $display("FAIL hold_second_done: got %b want 1", done); end
        end
        default: begin
          nvec++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin nmis++; $display("FAIL hold_idle_c%0d: got ready=%b busy=%b want 1/0", c, cmd_ready, busy); end
        end
      endcase
    end
    nvec++; if (wcnt !== 0) begin nmis++; $display("FAIL len0_writes: got %0d want 0", wcnt); end
    nvec++; if (bank[8] !== 32'd80) begin nmis++; $display("FAIL len0_bank8: got %0d want 80", bank[8]); end
  endtask

  task automatic test_reset_midop();
    int wcnt = 0;
    bit saw_done = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, DW'(100 + i));
    start_cmd(2'b00, 0, 0, 0, 16, 32'd9);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (write === 1'b1) wcnt++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    nvec++; if (wcnt !== 4) begin nmis++; $display("FAIL midrst_writes_before: got %0d want 4", wcnt); end
    @(negedge clk);
    nvec++; if (write !== 1'b1 || wr !== AW'(4)) begin nmis++; $display("FAIL midrst_fifth_write: got write=%b wr=%0d want 1/4", write, wr); end
    reset = 1'b0;
    #1;
    nvec++; if (write !== 1'b0) begin nmis++; $display("FAIL midrst_write_drop: got %b want 0", write); end
    nvec++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin nmis++; $display("FAIL midrst_idle: got busy=%b ready=%b want 0/1", busy, cmd_ready); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (write === 1'b1) wcnt++;
    end
    nvec++; if (saw_done !== 1'b0) begin nmis++; $display("FAIL midrst_done_pulse: got %b want 0", saw_done); end
    nvec++; if (wcnt !== 4) begin nmis++; $display("FAIL midrst_writes_after: got %0d want 4", wcnt); end
    nvec++; if (cmd_ready !== 1'b1) begin nmis++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (bank[i] !== ((i < 4) ? 32'd9 : DW'(100 + i))) begin
        nmis++; $display("FAIL midrst_bank[%0d]: got %0d want %0d", i, bank[i], (i < 4) ? 9 : 100 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_all();
    test_copy();
    test_fill_wrap();
    test_add();
    test_swap();
    test_len0_hold();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion want completion");
    $fatal(1);
  end

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
- Command-driven initiator for the 32x32 two-read/one-write register bank.
- Accepts one command at a time over a valid/ready handshake and drives the bank's `sr1`, `sr2`, `wr`, `write` and `writereg` ports.
- Executes FILL, COPY, ADD and SWAP operations.
- Used by test and boot logic to preload, move and combine bank contents without a CPU datapath.

Parameters:
- DW, 32, data width of bank words and of cmd_imm.
- AW, 5, register index width; bank depth is 2**AW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  operation: 00 FILL, 01 COPY, 10 ADD, 11 SWAP.
- cmd_a  in  AW  source index A.
- cmd_b  in  AW  source index B (ADD, SWAP).
- cmd_d  in  AW  destination base index (FILL, COPY, ADD).
- cmd_len  in  AW+1  element count, 0..32 (FILL, COPY).
- cmd_imm  in  DW  fill value.
- sr1  out  AW  bank read select 1.
- sr2  out  AW  bank read select 2.
- wr  out  AW  bank write index.
- write  out  1  bank write enable.
- writereg  out  DW  bank write data.
- readreg1  in  DW  bank read data 1; combinational from sr1.
- readreg2  in  DW  bank read data 2; combinational from sr2.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - `write`, `sr1`, `sr2`, `wr`, `busy` and `done` are 0; `writereg` is 0; `cmd_ready` is 1.
  - The internal count, latched command fields and SWAP temp are cleared.
- States:
  - IDLE → EXEC on accept.
  - EXEC → SWAP2 (SWAP only) or DONE.
  - SWAP2 → DONE.
  - DONE → IDLE.
- Handshake:
  - Accept occurs at a rising edge with `cmd_valid`=1 and `cmd_ready`=1.
  - `cmd_ready` = (state==IDLE).
  - All cmd_* fields are latched at accept; later changes to them are ignored.
- Outputs:
  - `busy` = (state!=IDLE).
  - `done` = (state==DONE), exactly one cycle.
  - `sr1`, `sr2`, `wr` and `write` are registered.
  - `writereg` is a combinational mux; it is 0 whenever `write`=0.
- Index arithmetic: all index arithmetic is modulo 32, so `cmd_d`+i and `cmd_a`+i wrap from 31 to 0. Register 0 is an ordinary register.
- FILL:
  - In EXEC, one write per cycle for i=0..len-1: `wr`=d+i, `writereg`=imm.
  - After the last write, go to DONE.
- COPY:
  - In EXEC, per cycle i: `sr1`=a+i, `wr`=d+i, `write`=1, `writereg`=`readreg1`.
  - Writes proceed in ascending order, element by element. Overlapping ranges therefore see already-written values: with d in (a, a+len), the pattern replicates.
- FILL/COPY with len=0:
  - No write is asserted.
  - EXEC lasts one cycle with `write`=0, then DONE.
- ADD:
  - One EXEC cycle: `sr1`=a, `sr2`=b, `wr`=d, `write`=1, `writereg`=(`readreg1`+`readreg2`) mod 2**DW. The carry is discarded.
  - `cmd_len` is ignored.
- SWAP:
  - EXEC: `sr1`=a, `sr2`=b, `wr`=a, `write`=1, `writereg`=`readreg2`; `readreg1` is captured into tmp at the same edge.
  - SWAP2: `wr`=b, `write`=1, `writereg`=tmp.
  - a==b writes the same value twice; the bank is unchanged.
- Latency, counted as cycles after the accept edge:
  - First write in cycle 1.
  - FILL/COPY: `done` in cycle len+1 (2 when len=0).
  - ADD: `done` in cycle 2.
  - SWAP: `done` in cycle 3.
  - `cmd_ready` returns the cycle after `done`.
- Back-to-back: minimum command spacing is total latency + 1 cycle. `cmd_valid` held high during busy is not consumed.
- Reset mid-operation:
  - `write` drops immediately and the state returns to IDLE.
  - Bank writes already completed remain; the remainder is abandoned and `done` is not pulsed.

Test Plan:
- Reset low then high, then FILL d=0 len=32 imm=0xA5A5A5A5 → 32 consecutive write cycles, wr=0..31; all regs read 0xA5A5A5A5; done at cycle 33.
- Preload reg[i]=i*10; COPY a=0 d=16 len=8 → reg[16..23]=0,10,..,70; reg[0..15] unchanged; done at cycle 9.
- FILL d=30 len=4 imm=7 → writes to wr=30,31,0,1 in order; reg[2]=unchanged.
- ADD a=3 b=4 d=5 with reg3=0xFFFFFFFF, reg4=2 → reg5=0x00000001, single write; SWAP a=1 b=2 with reg1=11, reg2=22 → reg1=22, reg2=11; a=b=6 → reg6 unchanged.
- COPY len=0, and cmd_valid held during busy → no write asserted, done at cycle 2; exactly one command consumed per cmd_ready window.
- Assert reset low during the 5th write of FILL d=0 len=16 imm=9 → write=0 immediately; reg[0..3]=9; reg[4..15] keep prior values; no done pulse; cmd_ready=1 after reset release.
